// File: rtl/pack_256to512_ctrl.sv
// Sequencing controller for the 256-to-512-bit packing shift register.
// Latency: sr_enable/sr_state are combinational from the handshake (0 cycles); out_valid rises the cycle after the closing beat or flush.
// Backpressure: in_ready follows out_ready while a full word waits, so a drain and a refill can share one cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_last      upstream beat handshake, in_last closes a stream
//   in_ready              beat accepted when in_valid & in_ready
//   flush                 single-cycle pulse closing a half-filled word
//   sr_enable, sr_state   shift register control (1 = load high, else load low)
//   out_valid/out_ready   512-bit word handshake towards the write path
//   out_last, out_half    word closes a stream / only the lower half is meaningful
//   beat_count/word_count wrapping statistics since reset
module pack_256to512_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             flush,
    output logic             sr_enable,
    output logic [2:0]       sr_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_half,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_nxt;
    logic       half_nxt;
    logic       accept;
    logic       drain;

    // In FULL a new beat may only land when the current word leaves at the
    // same edge: the load-low rewrites all 512 bits as downstream samples.
    assign in_ready  = (state == ST_FULL) ? out_ready : 1'b1;
    assign accept    = in_valid & in_ready;
    assign sr_enable = accept;
    assign sr_state  = (state == ST_HALF) ? 3'd1 : 3'd0;
    assign out_valid = (state == ST_FULL);
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        last_nxt  = out_last;
        half_nxt  = out_half;
        case (state)
            ST_HALF: begin
                if (accept) begin
                    // A coincident flush is folded into this word.
                    state_nxt = ST_FULL;
                    last_nxt  = in_last | flush;
                    half_nxt  = 1'b0;
                end else if (flush) begin
                    // Upper half is already zero from the load-low, no enable needed.
                    state_nxt = ST_FULL;
                    last_nxt  = 1'b1;
                    half_nxt  = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (accept && in_last) begin
                        state_nxt = ST_FULL;
                        last_nxt  = 1'b1;
                        half_nxt  = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_HALF;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                // EMPTY (and any unreachable encoding): flush has nothing to close.
                if (accept && in_last) begin
                    state_nxt = ST_FULL;
                    last_nxt  = 1'b1;
                    half_nxt  = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_HALF;
                end else begin
                    state_nxt = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            out_last   <= 1'b0;
            out_half   <= 1'b0;
            beat_count <= '0;
            word_count <= '0;
        end else begin
            state    <= state_nxt;
            out_last <= last_nxt;
            out_half <= half_nxt;
            if (accept) begin
                beat_count <= beat_count + CNT_W'(1);
            end
            if (drain) begin
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pack_256to512_ctrl.sv
module tb_pack_256to512_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             sr_enable;
    logic [2:0]       sr_state;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             out_half;
    logic [CNT_W-1:0] beat_count;
    logic [CNT_W-1:0] word_count;
    logic [255:0]     in_data = '0;

    int total = 0;
    int bad   = 0;

    pack_256to512_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .flush      (flush),
        .sr_enable  (sr_enable),
        .sr_state   (sr_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_half   (out_half),
        .beat_count (beat_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // The packing shift register this controller drives.
    logic [511:0] sr_reg;
    always @(posedge clk) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (sr_enable) begin
            if (sr_state == 3'd1) sr_reg[511:256] <= in_data;
            else                  sr_reg <= {256'd0, in_data};
        end
    end

    // Logs of what the DUT did, used by the literal checks.
    logic [2:0]   st_log[$];
    logic [511:0] wd_log[$];
    always @(posedge clk) begin
        if (!reset && sr_enable) st_log.push_back(sr_state);
        if (!reset && out_valid && out_ready) wd_log.push_back(sr_reg);
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a pending low beat and a completed word awaiting handoff.
    logic         m_have_low = 1'b0;
    logic [255:0] m_low = '0;
    logic         m_hold = 1'b0;
    logic [511:0] m_word = '0;
    logic         m_last = 1'b0;
    logic         m_half = 1'b0;
    int unsigned  m_beats = 0;
    int unsigned  m_words = 0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        if (reset) begin
            m_have_low = 1'b0;
            m_hold     = 1'b0;
            m_last     = 1'b0;
            m_half     = 1'b0;
            m_beats    = 0;
            m_words    = 0;
        end else begin
            exp_rdy = !m_hold || out_ready;
            acc     = in_valid && exp_rdy;
            check("in_ready", 512'(in_ready), 512'(exp_rdy));
            check("sr_enable", 512'(sr_enable), 512'(acc));
            if (acc) check("sr_state", 512'(sr_state), m_have_low ? 512'd1 : 512'd0);
            check("out_valid", 512'(out_valid), 512'(m_hold));
            if (m_hold) begin
                check("out_last", 512'(out_last), 512'(m_last));
                check("out_half", 512'(out_half), 512'(m_half));
                check("word_data", sr_reg, m_word);
            end
            check("beat_count", 512'(beat_count), 512'(m_beats));
            check("word_count", 512'(word_count), 512'(m_words));
            // advance the model by the edge that follows
            if (m_hold && out_ready) begin
                m_words++;
                m_hold = 1'b0;
            end
            if (acc) begin
                m_beats++;
                if (m_have_low) begin
                    m_hold = 1'b1; m_word = {in_data, m_low};
                    m_last = in_last | flush; m_half = 1'b0; m_have_low = 1'b0;
                end else if (in_last) begin
                    m_hold = 1'b1; m_word = {256'd0, in_data};
                    m_last = 1'b1; m_half = 1'b1;
                end else begin
                    m_have_low = 1'b1; m_low = in_data;
                end
            end else if (m_have_low && flush) begin
                m_hold = 1'b1; m_word = {256'd0, m_low};
                m_last = 1'b1; m_half = 1'b1; m_have_low = 1'b0;
            end
        end
    end

    task automatic cyc(input logic v, input logic l, input logic f, input logic r, input logic [255:0] d);
        in_valid  = v;
        in_last   = l;
        flush     = f;
        out_ready = r;
        in_data   = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        st_log.delete();
        wd_log.delete();
    endtask

    logic [255:0] da = {8{32'hA1A1_0001}};
    logic [255:0] db = {8{32'hB2B2_0002}};
    logic [255:0] dc = {8{32'hC3C3_0003}};
    logic [255:0] dd = {8{32'hD4D4_0004}};
    logic [255:0] dx = {8{32'h5E5E_0005}};
    logic [255:0] dy = {8{32'h6F6F_0006}};
    logic [255:0] z  = '0;

    initial begin
        // reset state
        do_reset();
        check("rst_out_valid", 512'(out_valid), 512'd0);
        check("rst_out_last", 512'(out_last), 512'd0);
        check("rst_out_half", 512'(out_half), 512'd0);
        check("rst_beats", 512'(beat_count), 512'd0);

        // four beats, out_ready held high
        cyc(1, 0, 0, 1, da);
        cyc(1, 0, 0, 1, db);
        cyc(1, 0, 0, 1, dc);
        cyc(1, 0, 0, 1, dd);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 0, z);
        check("t1_beats", 512'(beat_count), 512'd4);
        check("t1_words", 512'(word_count), 512'd2);
        check("t1_nst", 512'(st_log.size()), 512'd4);
        if (st_log.size() == 4)
            check("t1_st_seq", 512'({st_log[0], st_log[1], st_log[2], st_log[3]}), 512'(12'o0101));
        check("t1_nwd", 512'(wd_log.size()), 512'd2);
        if (wd_log.size() == 2) begin
            check("t1_w0", wd_log[0], {db, da});
            check("t1_w1", wd_log[1], {dd, dc});
        end

        // single beat with in_last
        do_reset();
        cyc(1, 1, 0, 0, da);
        check("t2_valid", 512'(out_valid), 512'd1);
        check("t2_last", 512'(out_last), 512'd1);
        check("t2_half", 512'(out_half), 512'd1);
        check("t2_data", sr_reg, {256'd0, da});
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 0, z);

        // beat, idle, flush
        do_reset();
        cyc(1, 0, 0, 1, da);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 1, 1, z);
        check("t3_valid", 512'(out_valid), 512'd1);
        check("t3_half", 512'(out_half), 512'd1);
        check("t3_last", 512'(out_last), 512'd1);
        check("t3_beats", 512'(beat_count), 512'd1);
        check("t3_nen", 512'(st_log.size()), 512'd1);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 0, z);

        // backpressure while FULL, then drain and refill together
        do_reset();
        cyc(1, 0, 0, 0, da);
        cyc(1, 0, 0, 0, db);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, dc);
            check("t4_hold_valid", 512'(out_valid), 512'd1);
            check("t4_hold_rdy", 512'(in_ready), 512'd0);
            check("t4_hold_en", 512'(sr_enable), 512'd0);
            check("t4_hold_data", sr_reg, {db, da});
        end
        cyc(1, 0, 0, 1, dc);
        check("t4_refill_valid", 512'(out_valid), 512'd0);
        check("t4_refill_beats", 512'(beat_count), 512'd3);
        check("t4_refill_words", 512'(word_count), 512'd1);
        cyc(1, 1, 0, 1, dd);
        check("t4_last", 512'(out_last), 512'd1);
        check("t4_half", 512'(out_half), 512'd0);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 0, z);
        if (wd_log.size() == 2) check("t4_w1", wd_log[1], {dd, dc});
        else check("t4_nwd", 512'(wd_log.size()), 512'd2);

        // in_last and flush together with the second beat
        do_reset();
        cyc(1, 0, 0, 1, da);
        cyc(1, 1, 1, 1, db);
        check("t5_last", 512'(out_last), 512'd1);
        check("t5_half", 512'(out_half), 512'd0);
        check("t5_data", sr_reg, {db, da});
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 1, z);
        check("t5_words", 512'(word_count), 512'd1);
        check("t5_beats", 512'(beat_count), 512'd2);

        // reset while half-filled
        do_reset();
        cyc(1, 0, 0, 1, da);
        do_reset();
        check("t6_beats", 512'(beat_count), 512'd0);
        check("t6_words", 512'(word_count), 512'd0);
        check("t6_valid", 512'(out_valid), 512'd0);
        cyc(1, 0, 0, 1, dx);
        cyc(1, 1, 0, 1, dy);
        cyc(0, 0, 0, 1, z);
        cyc(0, 0, 0, 0, z);
        if (st_log.size() == 2) check("t6_st0", 512'(st_log[0]), 512'd0);
        else check("t6_nst", 512'(st_log.size()), 512'd2);
        if (wd_log.size() == 1) check("t6_word", wd_log[0], {dy, dx});
        else check("t6_nwd", 512'(wd_log.size()), 512'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
